// File: rtl/apb_cmd_master.sv
// Fabric-side APB3 initiator: queues commands in a small FIFO, runs them in order
// as SETUP/ACCESS transfers and returns one response per command over valid/ready.
`timescale 1ns/1ps
module apb_cmd_master #(
   parameter int ADDR_W     = 32,
   parameter int FIFO_DEPTH = 4,
   parameter int TIMEOUT    = 0
) (
   input  logic              PCLK,
   input  logic              PRESET,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic              cmd_write,
   input  logic [ADDR_W-1:0] cmd_addr,
   input  logic [31:0]       cmd_wdata,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic              rsp_write,
   output logic [31:0]       rsp_rdata,
   output logic              rsp_err,
   output logic              busy,
   output logic              PSEL,
   output logic              PENABLE,
   output logic              PWRITE,
   output logic [ADDR_W-1:0] PADDR,
   output logic [31:0]       PWDATA,
   input  logic [31:0]       PRDATA,
   input  logic              PREADY,
   input  logic              PSLVERR
);

   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(FIFO_DEPTH);
   localparam logic [31:0] TMO_LAST = (TIMEOUT == 0) ? 32'd0 : 32'(TIMEOUT - 1);

   localparam logic [1:0] ST_IDLE   = 2'd0;
   localparam logic [1:0] ST_SETUP  = 2'd1;
   localparam logic [1:0] ST_ACCESS = 2'd2;

   logic [ADDR_W-1:0] fifo_addr  [FIFO_DEPTH];
   logic              fifo_write [FIFO_DEPTH];
   logic [31:0]       fifo_wdata [FIFO_DEPTH];

   logic [PTR_W-1:0]  wr_ptr_reg, rd_ptr_reg;
   logic [PTR_W:0]    count_reg;
   logic              ready_en_reg;
   logic [1:0]        state_reg;
   logic [31:0]       tmo_cnt_reg;

   logic              psel_reg, penable_reg, pwrite_reg;
   logic [ADDR_W-1:0] paddr_reg;
   logic [31:0]       pwdata_reg;
   logic              rsp_valid_reg, rsp_write_reg, rsp_err_reg;
   logic [31:0]       rsp_rdata_reg;

   logic push, pop;

   // ready_en_reg keeps cmd_ready low through reset and for the edge that ends it
   assign cmd_ready = ready_en_reg && (count_reg != FULL_CNT);
   assign push      = cmd_valid && cmd_ready;
   // a response being accepted this cycle frees the single response slot
   assign pop       = (state_reg == ST_IDLE) && (count_reg != '0) &&
                      (!rsp_valid_reg || rsp_ready);

   assign busy      = (count_reg != '0) || (state_reg != ST_IDLE) || rsp_valid_reg;
   assign PSEL      = psel_reg;
   assign PENABLE   = penable_reg;
   assign PWRITE    = pwrite_reg;
   assign PADDR     = paddr_reg;
   assign PWDATA    = pwdata_reg;
   assign rsp_valid = rsp_valid_reg;
   assign rsp_write = rsp_write_reg;
   assign rsp_rdata = rsp_rdata_reg;
   assign rsp_err   = rsp_err_reg;

   always_ff @(posedge PCLK) begin
      if (push) begin
         fifo_addr[wr_ptr_reg]  <= cmd_addr;
         fifo_write[wr_ptr_reg] <= cmd_write;
         fifo_wdata[wr_ptr_reg] <= cmd_wdata;
      end
   end

   always_ff @(posedge PCLK) begin
      if (PRESET) begin
         wr_ptr_reg   <= '0;
         rd_ptr_reg   <= '0;
         count_reg    <= '0;
         ready_en_reg <= 1'b0;
      end else begin
         ready_en_reg <= 1'b1;
         if (push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
         if (pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
         if (push && !pop)      count_reg <= count_reg + 1'b1;
         else if (pop && !push) count_reg <= count_reg - 1'b1;
      end
   end

   always_ff @(posedge PCLK) begin
      if (PRESET) begin
         state_reg     <= ST_IDLE;
         tmo_cnt_reg   <= '0;
         psel_reg      <= 1'b0;
         penable_reg   <= 1'b0;
         pwrite_reg    <= 1'b0;
         paddr_reg     <= '0;
         pwdata_reg    <= '0;
         rsp_valid_reg <= 1'b0;
         rsp_write_reg <= 1'b0;
         rsp_rdata_reg <= '0;
         rsp_err_reg   <= 1'b0;
      end else begin
         if (rsp_valid_reg && rsp_ready) rsp_valid_reg <= 1'b0;
         case (state_reg)
            ST_IDLE: begin
               if (pop) begin
                  paddr_reg  <= fifo_addr[rd_ptr_reg];
                  pwrite_reg <= fifo_write[rd_ptr_reg];
                  pwdata_reg <= fifo_write[rd_ptr_reg] ? fifo_wdata[rd_ptr_reg] : 32'd0;
                  psel_reg   <= 1'b1;
                  state_reg  <= ST_SETUP;
               end
            end
            ST_SETUP: begin
               penable_reg <= 1'b1;
               tmo_cnt_reg <= '0;
               state_reg   <= ST_ACCESS;
            end
            ST_ACCESS: begin
               if (PREADY) begin
                  rsp_valid_reg <= 1'b1;
                  rsp_write_reg <= pwrite_reg;
                  rsp_rdata_reg <= pwrite_reg ? 32'd0 : PRDATA;
                  rsp_err_reg   <= PSLVERR;
                  psel_reg      <= 1'b0;
                  penable_reg   <= 1'b0;
                  state_reg     <= ST_IDLE;
               end else if ((TIMEOUT != 0) && (tmo_cnt_reg == TMO_LAST)) begin
                  rsp_valid_reg <= 1'b1;
                  rsp_write_reg <= pwrite_reg;
                  rsp_rdata_reg <= 32'd0;
                  rsp_err_reg   <= 1'b1;
                  psel_reg      <= 1'b0;
                  penable_reg   <= 1'b0;
                  state_reg     <= ST_IDLE;
               end else begin
                  tmo_cnt_reg <= tmo_cnt_reg + 32'd1;
               end
            end
            default: state_reg <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_apb_cmd_master.sv
// Bench for apb_cmd_master: directed vector table, FIFO-full and reset sequences,
// and randomized traffic checked against an in-order memory/response model.
`timescale 1ns/1ps
module tb_apb_cmd_master;

   localparam int TMO = 8;

   logic        PCLK = 1'b0;
   logic        PRESET;
   logic        cmd_valid, cmd_ready, cmd_write;
   logic [31:0] cmd_addr, cmd_wdata;
   logic        rsp_valid, rsp_ready, rsp_write, rsp_err, busy;
   logic [31:0] rsp_rdata;
   logic        PSEL, PENABLE, PWRITE, PREADY, PSLVERR;
   logic [31:0] PADDR, PWDATA, PRDATA;

   always #5 PCLK = ~PCLK;

   apb_cmd_master #(.ADDR_W(32), .FIFO_DEPTH(4), .TIMEOUT(TMO)) dut (
      .PCLK(PCLK), .PRESET(PRESET),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
      .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_write(rsp_write),
      .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .busy(busy),
      .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE), .PADDR(PADDR),
      .PWDATA(PWDATA), .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR)
   );

   typedef struct { bit w; logic [31:0] a; logic [31:0] d; } cmd_t;
   typedef struct { int wt; bit er; } slv_t;
   typedef struct {
      bit w; logic [31:0] a; logic [31:0] d; int wt; bit er;
      logic [31:0] exp_rd; bit exp_er; int exp_pen;
   } vec_t;

   int checks = 0;
   int failures = 0;
   int resp_cnt = 0;
   cmd_t setup_q[$];
   cmd_t resp_q[$];
   slv_t slv_log[$];
   logic [31:0] model_mem [logic [31:0]];
   logic [31:0] slave_mem [logic [31:0]];
   bit mon_en = 0;
   bit use_forced = 1;
   int forced_wt = 0;
   bit forced_er = 0;
   bit rand_rdy = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge PCLK);
      #1;
   endtask

   function automatic logic [31:0] model_read(input logic [31:0] a);
      return model_mem.exists(a) ? model_mem[a] : 32'd0;
   endfunction

   // APB slave: per-transfer wait count and error flag, backing memory
   initial begin
      int acc;
      int wt;
      bit er;
      acc = 0; wt = 0; er = 0;
      PREADY = 0; PRDATA = 0; PSLVERR = 0;
      forever begin
         tick();
         if (PSEL && PENABLE) begin
            if (acc == 0) begin
               if (use_forced) begin
                  wt = forced_wt; er = forced_er;
               end else begin
                  wt = ($urandom % 8 == 0) ? 7 + int'($urandom % 3) : int'($urandom % 4);
                  er = ($urandom % 5 == 0);
               end
               slv_log.push_back('{wt, er});
            end
            if (acc >= wt) begin
               PREADY = 1; PSLVERR = er;
               if (PWRITE) begin
                  PRDATA = $urandom;
                  slave_mem[PADDR] = PWDATA;
               end else begin
                  PRDATA = slave_mem.exists(PADDR) ? slave_mem[PADDR] : 32'd0;
               end
            end else begin
               PREADY = 0; PRDATA = $urandom; PSLVERR = 1'($urandom % 2);
            end
            acc++;
         end else begin
            acc = 0; PREADY = 0; PSLVERR = 0; PRDATA = 0;
         end
      end
   end

   initial begin
      forever begin
         tick();
         if (rand_rdy) rsp_ready = ($urandom % 4 != 0);
      end
   end

   // Bus protocol and response scoreboard
   initial begin
      bit prev_psel, prev_setup, prev_hold;
      logic [31:0] la, ld, pr_rd;
      bit lw, pr_w, pr_e;
      cmd_t c;
      slv_t s;
      bit to;
      logic [31:0] exp_rd;
      prev_psel = 0; prev_setup = 0; prev_hold = 0;
      la = 0; ld = 0; lw = 0; pr_rd = 0; pr_w = 0; pr_e = 0;
      forever begin
         @(negedge PCLK);
         if (!mon_en) begin
            prev_psel = 0; prev_setup = 0; prev_hold = 0;
         end else begin
            chk("penable_without_psel", 32'(PENABLE & ~PSEL), 32'd0);
            if (prev_setup) chk("setup_to_access", 32'({PSEL, PENABLE}), 32'd3);
            if (PSEL && !PENABLE) begin
               chk("idle_gap_before_setup", 32'(prev_psel), 32'd0);
               if (setup_q.size() == 0) chk("setup_unexpected", 32'd1, 32'd0);
               else begin
                  c = setup_q.pop_front();
                  chk("setup_paddr", PADDR, c.a);
                  chk("setup_pwrite", 32'(PWRITE), 32'(c.w));
                  chk("setup_pwdata", PWDATA, c.w ? c.d : 32'd0);
               end
               la = PADDR; lw = PWRITE; ld = PWDATA;
            end
            if (PSEL && PENABLE) begin
               chk("access_paddr_stable", PADDR, la);
               chk("access_pwrite_stable", 32'(PWRITE), 32'(lw));
               chk("access_pwdata_stable", PWDATA, ld);
            end
            if (prev_hold) begin
               chk("rsp_hold_valid", 32'(rsp_valid), 32'd1);
               chk("rsp_hold_rdata", rsp_rdata, pr_rd);
               chk("rsp_hold_write", 32'(rsp_write), 32'(pr_w));
               chk("rsp_hold_err", 32'(rsp_err), 32'(pr_e));
            end
            if (rsp_valid && rsp_ready) begin
               if (resp_q.size() == 0 || slv_log.size() == 0)
                  chk("rsp_unexpected", 32'd1, 32'd0);
               else begin
                  c = resp_q.pop_front();
                  s = slv_log.pop_front();
                  to = (s.wt >= TMO);
                  exp_rd = (c.w || to) ? 32'd0 : model_read(c.a);
                  if (c.w && !to) model_mem[c.a] = c.d;
                  chk("rsp_write", 32'(rsp_write), 32'(c.w));
                  chk("rsp_err", 32'(rsp_err), 32'(to || s.er));
                  chk("rsp_rdata", rsp_rdata, exp_rd);
               end
               resp_cnt++;
               $display("rsp %0d: w=%0b rdata=%h err=%0b", resp_cnt, rsp_write, rsp_rdata, rsp_err);
            end
            prev_psel = PSEL;
            prev_setup = PSEL && !PENABLE;
            prev_hold = rsp_valid && !rsp_ready;
            pr_rd = rsp_rdata; pr_w = rsp_write; pr_e = rsp_err;
         end
      end
   end

   task automatic push_cmd(input bit w, input logic [31:0] a, input logic [31:0] d);
      int n;
      bit acc;
      n = 0;
      cmd_valid = 1; cmd_write = w; cmd_addr = a; cmd_wdata = d;
      do begin
         acc = cmd_ready;
         tick();
         n++;
      end while (!acc && n < 200);
      cmd_valid = 0;
      if (acc) begin
         setup_q.push_back('{w, a, d});
         resp_q.push_back('{w, a, d});
      end else chk("push_accept_timeout", 32'd0, 32'd1);
   endtask

   task automatic run_one(input bit w, input logic [31:0] a, input logic [31:0] d,
                          output logic [31:0] rd, output bit er, output bit wr,
                          output int lat, output int pen);
      push_cmd(w, a, d);
      lat = 1; pen = 0;
      while (!rsp_valid && lat < 60) begin
         tick();
         lat++;
         if (PENABLE) pen++;
      end
      if (!rsp_valid) chk("rsp_wait_timeout", 32'd0, 32'd1);
      rd = rsp_rdata; er = rsp_err; wr = rsp_write;
      tick();
   endtask

   task automatic wait_idle(input int limit, input string name);
      int n;
      n = 0;
      while ((busy || resp_q.size() != 0) && n < limit) begin
         tick();
         n++;
      end
      if (n >= limit) chk(name, 32'd0, 32'd1);
   endtask

   initial begin
      #1ms;
      $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t vecs[12];
      logic [31:0] rd;
      bit er, wr;
      int lat, pen, base;

      vecs[0]  = '{1'b1, 32'h4,        32'h000186A0, 0,   1'b0, 32'h0,        1'b0, 1};
      vecs[1]  = '{1'b0, 32'h4,        32'h0,        0,   1'b0, 32'h000186A0, 1'b0, 1};
      vecs[2]  = '{1'b0, 32'h8,        32'h0,        3,   1'b0, 32'h3,        1'b0, 4};
      vecs[3]  = '{1'b1, 32'h10,       32'hDEADBEEF, 1,   1'b1, 32'h0,        1'b1, 2};
      vecs[4]  = '{1'b0, 32'h10,       32'h0,        2,   1'b0, 32'hDEADBEEF, 1'b0, 3};
      vecs[5]  = '{1'b0, 32'h8,        32'h0,        0,   1'b1, 32'h3,        1'b1, 1};
      vecs[6]  = '{1'b1, 32'h20,       32'h12345678, 100, 1'b0, 32'h0,        1'b1, 8};
      vecs[7]  = '{1'b0, 32'h20,       32'h0,        0,   1'b0, 32'h0,        1'b0, 1};
      vecs[8]  = '{1'b0, 32'h4,        32'h0,        7,   1'b0, 32'h000186A0, 1'b0, 8};
      vecs[9]  = '{1'b0, 32'h4,        32'h0,        8,   1'b0, 32'h0,        1'b1, 8};
      vecs[10] = '{1'b1, 32'hFFFFFFFC, 32'hA5A5A5A5, 0,   1'b0, 32'h0,        1'b0, 1};
      vecs[11] = '{1'b0, 32'hFFFFFFFC, 32'h0,        0,   1'b0, 32'hA5A5A5A5, 1'b0, 1};

      slave_mem[32'h8] = 32'h3;
      model_mem[32'h8] = 32'h3;

      PRESET = 1; cmd_valid = 0; cmd_write = 0; cmd_addr = 0; cmd_wdata = 0; rsp_ready = 0;
      repeat (3) tick();
      chk("reset_cmd_ready", 32'(cmd_ready), 32'd0);
      chk("reset_rsp_valid", 32'(rsp_valid), 32'd0);
      chk("reset_busy", 32'(busy), 32'd0);
      chk("reset_psel_penable", 32'({PSEL, PENABLE, PWRITE}), 32'd0);
      chk("reset_paddr", PADDR, 32'd0);
      chk("reset_pwdata", PWDATA, 32'd0);
      chk("reset_rsp_fields", 32'({rsp_write, rsp_err}), 32'd0);
      chk("reset_rsp_rdata", rsp_rdata, 32'd0);
      PRESET = 0;
      chk("cmd_ready_low_at_release", 32'(cmd_ready), 32'd0);
      tick();
      chk("cmd_ready_after_release", 32'(cmd_ready), 32'd1);
      mon_en = 1;
      rsp_ready = 1;

      // Directed vectors, one command at a time
      use_forced = 1;
      for (int i = 0; i < 12; i++) begin
         forced_wt = vecs[i].wt;
         forced_er = vecs[i].er;
         run_one(vecs[i].w, vecs[i].a, vecs[i].d, rd, er, wr, lat, pen);
         chk($sformatf("vec%0d_rdata", i), rd, vecs[i].exp_rd);
         chk($sformatf("vec%0d_err", i), 32'(er), 32'(vecs[i].exp_er));
         chk($sformatf("vec%0d_write", i), 32'(wr), 32'(vecs[i].w));
         chk($sformatf("vec%0d_penable_cycles", i), 32'(pen), 32'(vecs[i].exp_pen));
         chk($sformatf("vec%0d_latency", i), 32'(lat), 32'(3 + vecs[i].exp_pen));
      end

      // Fill the FIFO while the response slot is blocked
      forced_wt = 0; forced_er = 0;
      rsp_ready = 0;
      base = resp_cnt;
      for (int i = 0; i < 5; i++)
         push_cmd(i % 2 == 0, 32'h100 + 32'(4 * i), 32'hC0DE0000 + 32'(i));
      chk("full_cmd_ready", 32'(cmd_ready), 32'd0);
      chk("full_busy", 32'(busy), 32'd1);
      repeat (6) tick();
      chk("full_rsp_valid", 32'(rsp_valid), 32'd1);
      chk("full_cmd_ready_held", 32'(cmd_ready), 32'd0);
      rsp_ready = 1;
      wait_idle(300, "full_drain_timeout");
      chk("full_rsp_count", 32'(resp_cnt - base), 32'd5);

      // Randomized traffic
      use_forced = 0;
      rand_rdy = 1;
      base = resp_cnt;
      for (int i = 0; i < 150; i++) begin
         repeat ($urandom % 3) begin
            cmd_write = 1'($urandom % 2); cmd_addr = $urandom; cmd_wdata = $urandom;
            tick();
         end
         push_cmd(1'($urandom % 2), 32'h200 + 32'(($urandom % 8) * 4), $urandom);
      end
      rand_rdy = 0;
      rsp_ready = 1;
      wait_idle(4000, "rand_drain_timeout");
      chk("rand_rsp_count", 32'(resp_cnt - base), 32'd150);
      chk("rand_slave_log_empty", 32'(slv_log.size()), 32'd0);

      // Reset in the middle of ACCESS with another command queued
      use_forced = 1; forced_wt = 100; forced_er = 0;
      push_cmd(1'b0, 32'h8, 32'h0);
      push_cmd(1'b1, 32'h30, 32'h55);
      lat = 0;
      while (!(PSEL && PENABLE) && lat < 20) begin
         tick();
         lat++;
      end
      chk("mid_reset_reached_access", 32'(PSEL && PENABLE), 32'd1);
      tick();
      mon_en = 0;
      PRESET = 1;
      tick();
      chk("mid_reset_psel_penable", 32'({PSEL, PENABLE}), 32'd0);
      chk("mid_reset_rsp_valid", 32'(rsp_valid), 32'd0);
      chk("mid_reset_busy", 32'(busy), 32'd0);
      chk("mid_reset_cmd_ready", 32'(cmd_ready), 32'd0);
      PRESET = 0;
      tick();
      chk("mid_reset_cmd_ready_back", 32'(cmd_ready), 32'd1);
      chk("mid_reset_busy_after", 32'(busy), 32'd0);
      setup_q.delete();
      resp_q.delete();
      slv_log.delete();
      mon_en = 1;
      forced_wt = 0;
      run_one(1'b0, 32'h8, 32'h0, rd, er, wr, lat, pen);
      chk("post_reset_read8", rd, 32'h3);
      chk("post_reset_latency", 32'(lat), 32'd4);
      run_one(1'b0, 32'h30, 32'h0, rd, er, wr, lat, pen);
      chk("post_reset_discarded_write", rd, 32'h0);
      chk("post_reset_err", 32'(er), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
